// File: rtl/pipe_regfile.sv
// 32x32 MIPS register file with per-register pending-write scoreboard and RAW stall.
// Optional write-through bypass enabled by defining PIPE_REGFILE_BYPASS_EN.

module pipe_regfile_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic             retire,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Coincident issue and retire cancel; out-of-range moves hold and flag.
    always_comb begin
        err = (issue && !retire && cnt == CNT_MAX) || (retire && !issue && cnt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (issue && !retire && cnt != CNT_MAX)
            cnt <= cnt + CNT_W'(1);
        else if (retire && !issue && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end
endmodule

module pipe_regfile #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  in_rd_waddr,
    input  logic        in_rd_wena,
    input  logic [31:0] in_rd_wdata,
    input  logic [4:0]  in_rs_raddr,
    input  logic [4:0]  in_rt_raddr,
    input  logic        in_rs_used,
    input  logic        in_rt_used,
    input  logic        in_issue_ena,
    input  logic [4:0]  in_issue_waddr,
    input  logic [4:0]  in_dbg_raddr,
    output logic [31:0] out_rs_rdata,
    output logic [31:0] out_rt_rdata,
    output logic [31:0] out_dbg_rdata,
    output logic        out_stall,
    output logic        out_err
);
    logic [31:0]            mem [32];
    logic [31:0][CNT_W-1:0] cnt;
    logic [31:0]            cnt_err;
    logic                   issue_hit, retire_hit;
    logic                   rs_busy, rt_busy;
    logic                   rs_retiring, rt_retiring;

    assign issue_hit  = in_issue_ena && !out_stall && in_issue_waddr != 5'd0;
    assign retire_hit = in_rd_wena && in_rd_waddr != 5'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (retire_hit) begin
            mem[in_rd_waddr] <= in_rd_wdata;
        end
    end

    assign cnt[0]     = '0;
    assign cnt_err[0] = 1'b0;

    for (genvar g = 1; g < 32; g++) begin : g_cnt
        pipe_regfile_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .issue  (issue_hit && in_issue_waddr == 5'(g)),
            .retire (retire_hit && in_rd_waddr == 5'(g)),
            .cnt    (cnt[g]),
            .err    (cnt_err[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_err <= 1'b0;
        else if (|cnt_err)
            out_err <= 1'b1;
    end

    assign rs_retiring   = retire_hit && in_rd_waddr == in_rs_raddr;
    assign rt_retiring   = retire_hit && in_rd_waddr == in_rt_raddr;
    assign out_dbg_rdata = (in_dbg_raddr == 5'd0) ? 32'd0 : mem[in_dbg_raddr];

`ifdef PIPE_REGFILE_BYPASS_EN
    // A lone pending write that retires this cycle is forwarded instead of stalling.
    assign out_rs_rdata = (in_rs_raddr == 5'd0) ? 32'd0 : rs_retiring ? in_rd_wdata : mem[in_rs_raddr];
    assign out_rt_rdata = (in_rt_raddr == 5'd0) ? 32'd0 : rt_retiring ? in_rd_wdata : mem[in_rt_raddr];
    assign rs_busy = in_rs_used && in_rs_raddr != 5'd0 && cnt[in_rs_raddr] != '0 &&
                     !(cnt[in_rs_raddr] == CNT_W'(1) && rs_retiring);
    assign rt_busy = in_rt_used && in_rt_raddr != 5'd0 && cnt[in_rt_raddr] != '0 &&
                     !(cnt[in_rt_raddr] == CNT_W'(1) && rt_retiring);
`else
    logic unused_retiring;
    assign unused_retiring = rs_retiring ^ rt_retiring;
    assign out_rs_rdata = (in_rs_raddr == 5'd0) ? 32'd0 : mem[in_rs_raddr];
    assign out_rt_rdata = (in_rt_raddr == 5'd0) ? 32'd0 : mem[in_rt_raddr];
    assign rs_busy = in_rs_used && in_rs_raddr != 5'd0 && cnt[in_rs_raddr] != '0;
    assign rt_busy = in_rt_used && in_rt_raddr != 5'd0 && cnt[in_rt_raddr] != '0;
`endif

    assign out_stall = rs_busy | rt_busy;
endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench for pipe_regfile: reset, read/write, RAW stall, scoreboard saturation.
module tb_pipe_regfile;
`ifdef PIPE_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  in_rd_waddr, in_rs_raddr, in_rt_raddr, in_issue_waddr, in_dbg_raddr;
    logic        in_rd_wena, in_rs_used, in_rt_used, in_issue_ena;
    logic [31:0] in_rd_wdata;
    logic [31:0] out_rs_rdata, out_rt_rdata, out_dbg_rdata;
    logic        out_stall, out_err;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pipe_regfile #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .in_rd_waddr(in_rd_waddr), .in_rd_wena(in_rd_wena), .in_rd_wdata(in_rd_wdata),
        .in_rs_raddr(in_rs_raddr), .in_rt_raddr(in_rt_raddr),
        .in_rs_used(in_rs_used), .in_rt_used(in_rt_used),
        .in_issue_ena(in_issue_ena), .in_issue_waddr(in_issue_waddr),
        .in_dbg_raddr(in_dbg_raddr),
        .out_rs_rdata(out_rs_rdata), .out_rt_rdata(out_rt_rdata), .out_dbg_rdata(out_dbg_rdata),
        .out_stall(out_stall), .out_err(out_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        in_rd_wena = 0; in_rd_waddr = 0; in_rd_wdata = 0;
        in_rs_raddr = 0; in_rt_raddr = 0; in_rs_used = 0; in_rt_used = 0;
        in_issue_ena = 0; in_issue_waddr = 0; in_dbg_raddr = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic issue(input logic [4:0] r);
        in_issue_ena = 1; in_issue_waddr = r;
    endtask

    task automatic retire(input logic [4:0] r, input logic [31:0] d);
        in_rd_wena = 1; in_rd_waddr = r; in_rd_wdata = d;
    endtask

    task automatic read_rs(input logic [4:0] r);
        in_rs_raddr = r; in_rs_used = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        in_rs_raddr = 5; in_dbg_raddr = 5;
        #1;
        chk("rst_rs", out_rs_rdata, 0);
        chk("rst_stall", {31'd0, out_stall}, 0);
        chk("rst_err", {31'd0, out_err}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        idle();

        // Reset mid-run with $5 still pending
        issue(5); tick();
        issue(5); tick();
        retire(5, 32'h1234); tick();
        read_rs(5); in_dbg_raddr = 5; #1;
        chk("mid_rs_data", out_rs_rdata, 32'h1234);
        chk("mid_pending", {31'd0, out_stall}, 1);
        #1 rst = 1; #1;
        chk("mid_rst_rs", out_rs_rdata, 0);
        chk("mid_rst_dbg", out_dbg_rdata, 0);
        chk("mid_rst_stall", {31'd0, out_stall}, 0);
        chk("mid_rst_err", {31'd0, out_err}, 0);
        #1 rst = 0;
        tick();

        // Basic write/read and $0
        issue(7); tick();
        read_rs(7); #1;
        chk("wr7_pending", {31'd0, out_stall}, 1);
        retire(7, 32'hDEADBEEF); in_rs_used = 0; tick();
        read_rs(7); #1;
        chk("wr7_data", out_rs_rdata, 32'hDEADBEEF);
        chk("wr7_stall", {31'd0, out_stall}, 0);
        retire(0, 32'hFFFFFFFF); tick();
        read_rs(0); in_rt_raddr = 0; in_dbg_raddr = 0; #1;
        chk("r0_rs", out_rs_rdata, 0);
        chk("r0_dbg", out_dbg_rdata, 0);
        chk("r0_err", {31'd0, out_err}, 0);
        chk("r0_stall", {31'd0, out_stall}, 0);

        // RAW stall on $3; the issue of $10 during the stall must be dropped
        issue(3); tick();
        read_rs(3); issue(10); #1;
        chk("raw_c1_stall", {31'd0, out_stall}, 1);
        tick();
        read_rs(3); #1;
        chk("raw_c2_stall", {31'd0, out_stall}, 1);
        tick();
        read_rs(3); retire(3, 32'hA5A5A5A5); in_dbg_raddr = 3; #1;
        chk("raw_ret_stall", {31'd0, out_stall}, BYP ? 32'd0 : 32'd1);
        chk("raw_ret_data", out_rs_rdata, BYP ? 32'hA5A5A5A5 : 32'd0);
        chk("raw_ret_dbg", out_dbg_rdata, 0);
        tick();
        read_rs(3); in_rt_raddr = 10; in_rt_used = 1; #1;
        chk("raw_after_stall", {31'd0, out_stall}, 0);
        chk("raw_after_data", out_rs_rdata, 32'hA5A5A5A5);
        tick();

        // Unused operand
        issue(4); tick();
        in_rt_raddr = 4; in_rt_used = 0; #1;
        chk("unused_rt", {31'd0, out_stall}, 0);
        in_rt_used = 1; #1;
        chk("used_rt", {31'd0, out_stall}, 1);
        tick();

        // Simultaneous issue/retire
        issue(9); tick();
        issue(9); retire(9, 32'h99); tick();
        read_rs(9); #1;
        chk("same_reg_cnt1", {31'd0, out_stall}, 1);
        issue(2); retire(9, 32'h900); in_rs_used = 0; tick();
        read_rs(9); in_rt_raddr = 2; #1;
        chk("diff_reg_r9", {31'd0, out_stall}, 0);
        chk("diff_reg_r9_data", out_rs_rdata, 32'h900);
        in_rt_used = 1; #1;
        chk("diff_reg_r2", {31'd0, out_stall}, 1);
        tick();

        // Self-dependent issue (addi $1,$1,1)
        read_rs(1); issue(1); #1;
        chk("self_dep_nostall", {31'd0, out_stall}, 0);
        tick();
        read_rs(1); #1;
        chk("self_dep_pending", {31'd0, out_stall}, 1);
        chk("pre_sat_err", {31'd0, out_err}, 0);
        tick();

        // Saturation on $6
        repeat (3) begin issue(6); tick(); end
        issue(6); #1;
        chk("sat_err_before", {31'd0, out_err}, 0);
        tick();
        chk("sat_err_set", {31'd0, out_err}, 1);
        retire(6, 32'h61); tick();
        retire(6, 32'h62); tick();
        read_rs(6); #1;
        chk("sat_cnt_left1", {31'd0, out_stall}, 1);
        retire(6, 32'h63); in_rs_used = 0; tick();
        read_rs(6); #1;
        chk("sat_cnt_zero", {31'd0, out_stall}, 0);
        chk("sat_err_sticky", {31'd0, out_err}, 1);

        // Underflow after reset
        #1 rst = 1; #1;
        chk("uf_rst_err", {31'd0, out_err}, 0);
        #1 rst = 0;
        tick();
        retire(6, 32'h5); tick();
        read_rs(6); in_dbg_raddr = 6; #1;
        chk("uf_err", {31'd0, out_err}, 1);
        chk("uf_cnt_zero", {31'd0, out_stall}, 0);
        chk("uf_data", out_dbg_rdata, 32'h5);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pipe_regfile.md
Name: pipe_regfile

Overview:
- 32x32 general-purpose register file for the 5-stage MIPS pipeline.
- Receives the writeback port from the WB stage and serves the two ID-stage source-operand reads.
- Keeps a per-register pending-write scoreboard. This produces the ID-stage RAW stall and removes the need for external hazard bookkeeping.
- Also provides a debug read port for bench and board inspection.

Parameters:
- CNT_W, 2, width of each per-register pending-write counter. The maximum count is 2^CNT_W-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_rd_waddr  in  5  WB destination register
- in_rd_wena  in  1  WB write enable
- in_rd_wdata  in  32  WB write data
- in_rs_raddr  in  5  ID source register rs
- in_rt_raddr  in  5  ID source register rt
- in_rs_used  in  1  instruction in ID actually reads rs
- in_rt_used  in  1  instruction in ID actually reads rt
- in_issue_ena  in  1  instruction in ID writes a register and issues this cycle
- in_issue_waddr  in  5  destination register of the issuing instruction
- in_dbg_raddr  in  5  debug read address
- out_rs_rdata  out  32  rs read data
- out_rt_rdata  out  32  rt read data
- out_dbg_rdata  out  32  debug read data
- out_stall  out  1  RAW hazard; ID/IF must hold
- out_err  out  1  sticky scoreboard over/underflow flag

Behaviour:
- Reset (async, rst=1):
  - all 32 registers are cleared to 0.
  - all counters are cleared to 0.
  - out_err is cleared to 0.
  - Consequently out_*_rdata=0 and out_stall=0 while rst is high.
  - Reset asserted mid-operation discards all pending counts immediately.
- Write:
  - On the rising clk edge with in_rd_wena=1 and in_rd_waddr!=0, reg[waddr] <= wdata.
  - Writes to $0 are ignored. $0 always reads 0.
- Reads: combinational, zero latency.
  - out_rs_rdata = (rs==0) ? 0 : reg[rs]. out_rt_rdata and out_dbg_rdata follow the same rule.
  - Debug port never bypasses.
- Scoreboard, one counter per register 1..31 (register 0 has no counter):
  - issue_hit = in_issue_ena && !out_stall && in_issue_waddr!=0
  - retire_hit = in_rd_wena && in_rd_waddr!=0
  - Same register hit by both in one cycle: count unchanged.
  - issue_hit only: count+1. If count is already at max, count holds and out_err is set.
  - retire_hit only: count-1. If count is 0, count holds at 0 and out_err is set.
  - out_err clears only on reset.
- Stall (combinational):
  - rs_busy = in_rs_used && rs!=0 && cnt[rs]!=0, minus the bypass exception below. rt_busy is defined the same way.
  - out_stall = rs_busy | rt_busy.
  - in_issue_ena is ignored while out_stall=1; the instruction is held in ID and issues later.
- Simultaneous events:
  - Issue and retire of different registers in the same cycle are both applied.
  - An issue to a register that is also a source of the same instruction is not a hazard unless that register is already pending (e.g. addi $1,$1,1).

Optional Feature:
- Macro: PIPE_REGFILE_BYPASS_EN.
- Defined (write-through bypass):
  - If retire_hit and in_rd_waddr equals the read address, out_rs_rdata/out_rt_rdata return in_rd_wdata in the same cycle.
  - rs_busy/rt_busy are forced to 0 when cnt==1 and that single pending write is retiring this cycle. This saves one stall cycle per dependency.
- Undefined:
  - Reads return the stored value only.
  - A register with cnt!=0 stalls even in its retire cycle; the stall drops the cycle after the write.

Test Plan:
- Reset mid-run: write 0x1234 to $5, assert rst asynchronously between edges -> reg5 reads 0, out_stall=0, out_err=0 before the next edge.
- Write/read basic: WB writes 0xDEADBEEF to $7 -> next cycle rs=7 reads 0xDEADBEEF. WB writes 0xFFFFFFFF to $0 -> $0 reads 0, no counter change.
- RAW stall: issue to $3, three cycles later retire $3 with 0xA5A5A5A5 while ID reads rs=3, rs_used=1.
  - Bypass off: stall high through the retire cycle, low the next cycle, data 0xA5A5A5A5.
  - Bypass on: stall low and data 0xA5A5A5A5 in the retire cycle.
- Unused operand: $4 pending, rt=4 with rt_used=0 -> out_stall=0.
- Simultaneous issue and retire of $9 with count 1 -> count stays 1. Issue $2 while retiring $9 -> both applied.
- Saturation/underflow: with CNT_W=2, issue $6 four times without retire -> count 3, out_err=1 sticky. After reset, retire $6 with count 0 -> out_err=1, count 0.
